// File: rtl/fpu_share_arbiter_pkg.sv
// Shared constants and types for the FPU sharing arbiter.
// Float layout is {sign, exp[5:0], mant[24:0]} with exponent bias 31.
package fpu_share_arbiter_pkg;

  localparam int FP_W     = 32;
  localparam int EXP_W    = 6;
  localparam int MANT_W   = 25;
  localparam int EXP_BIAS = 31;
  localparam int STATUS_W = 4;

  // Bit positions inside the FPU status_out word.
  localparam int ST_INEXACT   = 0;
  localparam int ST_UNDERFLOW = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_ZERO      = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/fpu_share_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot grant of the first asserted
// request found searching upward from rr_ptr, wrapping at NUM_REQ.
module rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  always_comb begin
    int   idx;
    logic found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_share_arbiter.sv
// Time-shares one FPU adder among NUM_REQ requesters: round-robin grant,
// one-cycle FPU reset pulse, fixed-latency wait, then a held response.
module fpu_share_arbiter
  import fpu_share_arbiter_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int FPU_LATENCY = 6,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*FP_W-1:0] req_op_a,
  input  logic [NUM_REQ*FP_W-1:0] req_op_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [FP_W-1:0]         resp_data,
  output logic [STATUS_W-1:0]     resp_status,
  output logic                    busy,
  output logic                    fpu_reset,
  output logic [FP_W-1:0]         fpu_op_a,
  output logic [FP_W-1:0]         fpu_op_b,
  input  logic [FP_W-1:0]         fpu_data,
  input  logic [STATUS_W-1:0]     fpu_status
);

  localparam int                LAT_W    = $clog2(FPU_LATENCY + 1);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(FPU_LATENCY - 1);

  arb_state_t          state_q,       state_d;
  logic [ID_W-1:0]     rr_ptr_q,      rr_ptr_d;
  logic [LAT_W-1:0]    lat_cnt_q,     lat_cnt_d;
  logic [ID_W-1:0]     resp_id_q,     resp_id_d;
  logic                resp_valid_q,  resp_valid_d;
  logic [FP_W-1:0]     resp_data_q,   resp_data_d;
  logic [STATUS_W-1:0] resp_status_q, resp_status_d;
  logic                busy_q,        busy_d;
  logic                fpu_reset_q,   fpu_reset_d;
  logic [FP_W-1:0]     fpu_op_a_q,    fpu_op_a_d;
  logic [FP_W-1:0]     fpu_op_b_q,    fpu_op_b_d;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_id  (grant_id)
  );

  // The reset term keeps req_ready low while the block is held in reset.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    lat_cnt_d     = lat_cnt_q;
    resp_id_d     = resp_id_q;
    resp_valid_d  = resp_valid_q;
    resp_data_d   = resp_data_q;
    resp_status_d = resp_status_q;
    fpu_op_a_d    = fpu_op_a_q;
    fpu_op_b_d    = fpu_op_b_q;
    req_ready     = '0;

    case (state_q)
      IDLE: begin
        if (reset) begin
          req_ready = grant;
        end
        if (|grant) begin
          fpu_op_a_d = req_op_a[int'(grant_id)*FP_W +: FP_W];
          fpu_op_b_d = req_op_b[int'(grant_id)*FP_W +: FP_W];
          resp_id_d  = grant_id;
          rr_ptr_d   = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        lat_cnt_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          resp_data_d   = fpu_data;
          resp_status_d = fpu_status;
          resp_valid_d  = 1'b1;
          state_d       = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with it.
    busy_d      = (state_d != IDLE);
    fpu_reset_d = (state_d != LAUNCH);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      lat_cnt_q     <= '0;
      resp_id_q     <= '0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      resp_status_q <= '0;
      busy_q        <= 1'b0;
      fpu_reset_q   <= 1'b0;
      fpu_op_a_q    <= '0;
      fpu_op_b_q    <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      lat_cnt_q     <= lat_cnt_d;
      resp_id_q     <= resp_id_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      resp_status_q <= resp_status_d;
      busy_q        <= busy_d;
      fpu_reset_q   <= fpu_reset_d;
      fpu_op_a_q    <= fpu_op_a_d;
      fpu_op_b_q    <= fpu_op_b_d;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_data   = resp_data_q;
  assign resp_status = resp_status_q;
  assign busy        = busy_q;
  assign fpu_reset   = fpu_reset_q;
  assign fpu_op_a    = fpu_op_a_q;
  assign fpu_op_b    = fpu_op_b_q;

endmodule
